// File: rtl/mm_systolic_sequencer_if.sv
// Bus between the matmul top level, the sequencer and the 3x3 PE grid.
// Master side drives operands and the PE results; slave is the sequencer.
interface mm_systolic_sequencer_if #(
    parameter int DW = 8
);
    logic            start;
    logic [9*DW-1:0] a_mat;
    logic [9*DW-1:0] b_mat;
    logic [9*DW-1:0] c_in;
    logic [DW-1:0]   a_feed0;
    logic [DW-1:0]   a_feed1;
    logic [DW-1:0]   a_feed2;
    logic [DW-1:0]   b_feed0;
    logic [DW-1:0]   b_feed1;
    logic [DW-1:0]   b_feed2;
    logic            pe_clear;
    logic            pe_en;
    logic [9*DW-1:0] c_mat;
    logic            busy;
    logic            done;

    modport master (
        output start, a_mat, b_mat, c_in,
        input  a_feed0, a_feed1, a_feed2,
        input  b_feed0, b_feed1, b_feed2,
        input  pe_clear, pe_en, c_mat, busy, done
    );

    modport slave (
        input  start, a_mat, b_mat, c_in,
        output a_feed0, a_feed1, a_feed2,
        output b_feed0, b_feed1, b_feed2,
        output pe_clear, pe_en, c_mat, busy, done
    );
endinterface

// File: rtl/mm_systolic_sequencer.sv
// Sequences one 3x3 product through the output-stationary PE array.
// Skews operands onto the array edges, drains, captures C, signals done.
module mm_systolic_sequencer #(
    parameter int PE_LAT = 1,
    parameter int DW     = 8
) (
    input logic                   clk,
    input logic                   reset,
    mm_systolic_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FEED,
        S_DRAIN,
        S_CAPTURE,
        S_DONE
    } state_t;

    // DRAIN runs for t = 0 .. PE_LAT+1, i.e. 2+PE_LAT cycles.
    localparam logic [2:0] DRAIN_LAST = 3'(PE_LAT + 1);
    localparam logic [2:0] FEED_LAST  = 3'd4;

    state_t                 state;
    logic [2:0]             t;
    logic [9*DW-1:0]        a_q;
    logic [9*DW-1:0]        b_q;
    logic [2:0][DW-1:0]     a_f;
    logic [2:0][DW-1:0]     b_f;
    logic [9*DW-1:0]        c_q;
    logic                   clr_q;
    logic                   en_q;
    logic                   busy_q;
    logic                   done_q;

    // Row i at step tt carries a[i][tt-i]; zero outside the 3-wide window.
    function automatic logic [DW-1:0] a_sel(
        input logic [9*DW-1:0] m,
        input logic [2:0]      tt,
        input int              i
    );
        int k;
        k = int'(tt) - i;
        if (k >= 0 && k <= 2)
            return m[DW*(3*i+k) +: DW];
        return '0;
    endfunction

    // Column j at step tt carries b[tt-j][j]; zero outside the window.
    function automatic logic [DW-1:0] b_sel(
        input logic [9*DW-1:0] m,
        input logic [2:0]      tt,
        input int              j
    );
        int k;
        k = int'(tt) - j;
        if (k >= 0 && k <= 2)
            return m[DW*(3*k+j) +: DW];
        return '0;
    endfunction

    // Control FSM; every output is a register updated with the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            t      <= '0;
            a_q    <= '0;
            b_q    <= '0;
            a_f    <= '0;
            b_f    <= '0;
            c_q    <= '0;
            clr_q  <= 1'b0;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state  <= S_LOAD;
                        a_q    <= bus.a_mat;
                        b_q    <= bus.b_mat;
                        clr_q  <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state <= S_FEED;
                    t     <= '0;
                    clr_q <= 1'b0;
                    en_q  <= 1'b1;
                    for (int i = 0; i < 3; i++) begin
                        a_f[i] <= a_sel(a_q, 3'd0, i);
                        b_f[i] <= b_sel(b_q, 3'd0, i);
                    end
                end
                S_FEED: begin
                    if (t == FEED_LAST) begin
                        state <= S_DRAIN;
                        t     <= '0;
                        a_f   <= '0;
                        b_f   <= '0;
                    end else begin
                        t <= t + 3'd1;
                        for (int i = 0; i < 3; i++) begin
                            a_f[i] <= a_sel(a_q, t + 3'd1, i);
                            b_f[i] <= b_sel(b_q, t + 3'd1, i);
                        end
                    end
                end
                S_DRAIN: begin
                    if (t == DRAIN_LAST) begin
                        state <= S_CAPTURE;
                        t     <= '0;
                        en_q  <= 1'b0;
                    end else begin
                        t <= t + 3'd1;
                    end
                end
                S_CAPTURE: begin
                    state  <= S_DONE;
                    c_q    <= bus.c_in;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                S_DONE: begin
                    if (!bus.start) begin
                        state  <= S_IDLE;
                        done_q <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.a_feed0  = a_f[0];
    assign bus.a_feed1  = a_f[1];
    assign bus.a_feed2  = a_f[2];
    assign bus.b_feed0  = b_f[0];
    assign bus.b_feed1  = b_f[1];
    assign bus.b_feed2  = b_f[2];
    assign bus.pe_clear = clr_q;
    assign bus.pe_en    = en_q;
    assign bus.c_mat    = c_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_mm_systolic_sequencer.sv
// Bench for mm_systolic_sequencer: PE_LAT=1 and PE_LAT=3 side by side,
// driven by a behavioural minifloat PE grid.
module tb_mm_systolic_sequencer;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic [9*DW-1:0] a_mat;
    logic [9*DW-1:0] b_mat;
    logic [9*DW-1:0] cin1;
    logic [9*DW-1:0] cin3;

    always #5 clk = ~clk;

    mm_systolic_sequencer_if #(.DW(DW)) bus1 ();
    mm_systolic_sequencer_if #(.DW(DW)) bus3 ();

    assign bus1.start = start;
    assign bus1.a_mat = a_mat;
    assign bus1.b_mat = b_mat;
    assign bus1.c_in  = cin1;
    assign bus3.start = start;
    assign bus3.a_mat = a_mat;
    assign bus3.b_mat = b_mat;
    assign bus3.c_in  = cin3;

    mm_systolic_sequencer #(.PE_LAT(1), .DW(DW)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    mm_systolic_sequencer #(.PE_LAT(3), .DW(DW)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.slave)
    );

    localparam logic [71:0] A_M = {
        8'h30, 8'h20, 8'h90,
        8'hB8, 8'h30, 8'h20,
        8'h30, 8'h20, 8'h20
    };
    localparam logic [71:0] B_M = {
        8'h20, 8'h20, 8'h30,
        8'h30, 8'h30, 8'h30,
        8'h44, 8'h44, 8'h30
    };
    localparam logic [71:0] C_EXP = {
        8'h18, 8'h18, 8'h34,
        8'h38, 8'h38, 8'h00,
        8'h42, 8'h42, 8'h40
    };

    // Minifloat 1/3/4, bias 3, to real.
    function automatic real dec(input logic [7:0] x);
        real v;
        int  e;
        e = int'(x[6:4]);
        if (e == 0) begin
            v = real'(x[3:0]) / 64.0;
        end else begin
            v = 1.0 + real'(x[3:0]) / 16.0;
            for (int k = 3; k < e; k++) v = v * 2.0;
            for (int k = e; k < 3; k++) v = v / 2.0;
        end
        return x[7] ? -v : v;
    endfunction

    // Real to minifloat; only normal, exactly representable values needed.
    function automatic logic [7:0] enc(input real v);
        logic s;
        real  m;
        int   e;
        int   mt;
        logic [2:0] ef;
        logic [3:0] mf;
        if (v == 0.0) return 8'h00;
        s = (v < 0.0);
        m = s ? -v : v;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        mt = int'((m - 1.0) * 16.0);
        ef = 3'(e + 3);
        mf = 4'(mt);
        return {s, ef, mf};
    endfunction

    // Behavioural output-stationary grids; unit 1 adds 2 cycles of latency.
    real        acc [2][3][3];
    real        d1 [3][3];
    real        d2 [3][3];
    logic [7:0] ar [2][3][3];
    logic [7:0] br [2][3][3];
    logic [7:0] af [2][3];
    logic [7:0] bf [2][3];
    logic       clr [2];
    logic       en [2];

    always_comb begin
        af[0][0] = bus1.a_feed0; af[0][1] = bus1.a_feed1;
        af[0][2] = bus1.a_feed2;
        bf[0][0] = bus1.b_feed0; bf[0][1] = bus1.b_feed1;
        bf[0][2] = bus1.b_feed2;
        af[1][0] = bus3.a_feed0; af[1][1] = bus3.a_feed1;
        af[1][2] = bus3.a_feed2;
        bf[1][0] = bus3.b_feed0; bf[1][1] = bus3.b_feed1;
        bf[1][2] = bus3.b_feed2;
        clr[0] = bus1.pe_clear; en[0] = bus1.pe_en;
        clr[1] = bus3.pe_clear; en[1] = bus3.pe_en;
    end

    // Grid update: clear, or shift operands right/down and accumulate.
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) begin
                    if (clr[u]) begin
                        acc[u][i][j] <= 0.0;
                        ar[u][i][j]  <= 8'h00;
                        br[u][i][j]  <= 8'h00;
                    end else if (en[u]) begin
                        acc[u][i][j] <= acc[u][i][j] +
                            dec((j == 0) ? af[u][i] : ar[u][i][j-1]) *
                            dec((i == 0) ? bf[u][j] : br[u][i-1][j]);
                        ar[u][i][j] <= (j == 0) ? af[u][i] : ar[u][i][j-1];
                        br[u][i][j] <= (i == 0) ? bf[u][j] : br[u][i-1][j];
                    end
                end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                d1[i][j] <= acc[1][i][j];
                d2[i][j] <= d1[i][j];
            end
    end

    // Pack grid results onto c_in.
    always_comb begin
        cin1 = '0;
        cin3 = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                cin1[8*(3*i+j) +: 8] = enc(acc[0][i][j]);
                cin3[8*(3*i+j) +: 8] = enc(d2[i][j]);
            end
    end

    typedef struct {
        logic [7:0] a0, a1, a2;
        logic [7:0] b0, b1, b2;
        logic       clr, en, busy, done;
        logic       en3, done3;
    } vec_t;

    vec_t vt [13];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [71:0] act,
                       input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [53:0] pack_v(input vec_t v);
        return {v.a0, v.a1, v.a2, v.b0, v.b1, v.b2,
                v.clr, v.en, v.busy, v.done, v.en3, v.done3};
    endfunction

    function automatic logic [53:0] pack_dut();
        return {bus1.a_feed0, bus1.a_feed1, bus1.a_feed2,
                bus1.b_feed0, bus1.b_feed1, bus1.b_feed2,
                bus1.pe_clear, bus1.pe_en, bus1.busy, bus1.done,
                bus3.pe_en, bus3.done};
    endfunction

    task automatic chk_zero(input string nm);
        chk({nm, "_ctl1"}, {18'b0, pack_dut()}, 72'b0);
        chk({nm, "_ctl3"},
            {64'b0, bus3.pe_clear, bus3.pe_en, bus3.busy, bus3.done,
             4'b0}, 72'b0);
        chk({nm, "_cmat1"}, bus1.c_mat, 72'b0);
        chk({nm, "_cmat3"}, bus3.c_mat, 72'b0);
    endtask

    // One run from the sampling edge E0 through cycle 13.
    task automatic run_table(input string nm, input bit perturb);
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s_cyc%0d", nm, k),
                {18'b0, pack_dut()}, {18'b0, pack_v(vt[k-1])});
            if (perturb && k == 3) begin
                a_mat = ~A_M;
                b_mat = 72'h0;
            end
            if (k == 11) chk({nm, "_cmat1"}, bus1.c_mat, C_EXP);
            if (k == 13) begin
                chk({nm, "_cmat3"}, bus3.c_mat, C_EXP);
                chk({nm, "_cmat1_held"}, bus1.c_mat, C_EXP);
            end
        end
        a_mat = A_M;
        b_mat = B_M;
    endtask

    initial begin
        //         a0     a1     a2     b0     b1     b2  clr en by dn e3 d3
        vt[0]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 1, 0, 0, 0};
        vt[1]  = '{8'h20, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 0, 1, 1, 0, 1, 0};
        vt[2]  = '{8'h20, 8'h20, 8'h00, 8'h30, 8'h44, 8'h00, 0, 1, 1, 0, 1, 0};
        vt[3]  = '{8'h30, 8'h30, 8'h90, 8'h30, 8'h30, 8'h44, 0, 1, 1, 0, 1, 0};
        vt[4]  = '{8'h00, 8'hB8, 8'h20, 8'h00, 8'h20, 8'h30, 0, 1, 1, 0, 1, 0};
        vt[5]  = '{8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'h20, 0, 1, 1, 0, 1, 0};
        vt[6]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 1, 0, 1, 0};
        vt[7]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 1, 0, 1, 0};
        vt[8]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 1, 0, 1, 0};
        vt[9]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0, 1, 0};
        vt[10] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 1, 0};
        vt[11] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0, 0};
        vt[12] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0, 1};

        reset = 1'b0;
        start = 1'b1;
        a_mat = A_M;
        b_mat = B_M;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset_hold");

        // Release with start high: next edge is the sampling edge E0.
        reset = 1'b1;
        run_table("run1", 1'b0);

        @(posedge clk);
        #1;
        chk("done_held", {70'b0, bus1.done, bus3.done}, 72'd3);

        start = 1'b0;
        @(posedge clk);
        #1;
        chk("done_drop", {68'b0, bus1.done, bus1.busy, bus3.done,
                          bus3.busy}, 72'd0);

        // Second run, operands scrambled mid-FEED.
        start = 1'b1;
        run_table("run2", 1'b1);

        // Abort in FEED t=3 (cycle 5).
        start = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_abort", {70'b0, bus1.busy, bus1.pe_en}, 72'd3);
        reset = 1'b0;
        #1;
        chk_zero("abort");
        @(posedge clk);
        #1;
        chk_zero("abort_held");
        reset = 1'b1;
        run_table("run3", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mm_systolic_sequencer.md
# mm_systolic_sequencer

Controller that sequences one 3×3 product C = A×B through the output-stationary systolic PE array.
- Latches both operand matrices on a start request, then streams them into the array's row and column edges with the diagonal skew the array requires.
- Clears and enables the PE accumulators, waits out the array drain, captures the nine results and signals done.
- Sits between the matrix-multiplier top level and the 3×3 PE grid; performs no arithmetic on operands.

## Interface
- PE_LAT, 1: PE multiply-accumulate latency in cycles (1..4).
- DW, 8: operand/result width; 8-bit minifloat, 1 sign, 3 exponent (bias 3), 4 mantissa bits; 8'h00 = +0.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level request; sampled only in IDLE.
- a_mat  in  9*DW  A; a_ij at [DW*(3i+j) +: DW].
- b_mat  in  9*DW  B; same packing.
- c_in  in  9*DW  PE accumulator outputs, same packing.
- a_feed0..a_feed2  out  DW each  row-edge operand for array rows 0..2.
- b_feed0..b_feed2  out  DW each  column-edge operand for array columns 0..2.
- pe_clear  out  1  synchronous accumulator clear to all PEs.
- pe_en  out  1  PE shift/accumulate enable.
- c_mat  out  9*DW  captured result matrix.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  result valid.

## Operation
- States: IDLE, LOAD, FEED, DRAIN, CAPTURE, DONE; all outputs are registered.
- IDLE:
  - Goes to LOAD when start=1.
- LOAD (1 cycle):
  - Latches a_mat/b_mat into internal registers.
  - pe_clear=1, pe_en=0.
  - Goes to FEED with t=0.
- FEED (5 cycles, t=0..4):
  - pe_en=1.
  - a_feed_i = a[i][t-i] when 0≤t-i≤2, else 8'h00.
  - b_feed_j = b[t-j][j] when 0≤t-j≤2, else 8'h00.
  - After t=4, goes to DRAIN.
- DRAIN (2+PE_LAT cycles):
  - pe_en=1, all feeds 8'h00.
  - Lets PE(2,2) consume its last operands (array time 6) and complete accumulation.
- CAPTURE (1 cycle):
  - pe_en=0; c_mat <= c_in.
  - Goes to DONE.
- DONE:
  - done=1; c_mat held stable.
  - Stays while start=1; returns to IDLE when start=0.
  - Holding start high never triggers a second run.
- Counter t is 3 bits and is shared by FEED and DRAIN.
- Operand registers and c_mat are never modified outside LOAD and CAPTURE.
- start changes outside IDLE/DONE are ignored; a run cannot be aborted except by reset.
- Input matrices may change after LOAD without affecting the run in progress.

## Timing
- Reset (reset=0, asynchronous):
  - State = IDLE, t=0.
  - All feeds, c_mat and operand registers = 0.
  - pe_clear=0, pe_en=0, busy=0, done=0.
  - Reset asserted mid-run aborts immediately to this state; the first run after reset release needs start=1 sampled in IDLE.
- Cycle numbering: edge E0 samples start=1 in IDLE.
  - Cycle 1: LOAD (pe_clear=1, busy=1).
  - Cycles 2..6: FEED.
  - Cycles 7..(8+PE_LAT): DRAIN.
  - Next cycle: CAPTURE.
  - Following cycle: done=1 and c_mat valid.
  - PE_LAT=1: done first high in cycle 11, i.e. latency 11 cycles from the sampling edge.
- done deasserts the cycle after start=0 is sampled in DONE.
- A new start may be accepted on the edge after IDLE is re-entered.
- pe_clear and pe_en are never high in the same cycle.

## Test plan
- Reset: hold reset=0 with start=1 → all outputs 0, state IDLE. Release reset → LOAD on the next edge.
- Skew check: A = [0.5,0.5,1; 0.5,1,-1.5; -0.25,0.5,1] = 0x20,0x20,0x30 / 0x20,0x30,0xB8 / 0x90,0x20,0x30. B = [1,2.5,2.5; 1,1,1; 1,0.5,0.5] = 0x30,0x44,0x44 / 0x30,0x30,0x30 / 0x30,0x20,0x20.
  - t=0: a_feed=(0x20,0,0), b_feed=(0x30,0,0).
  - t=2: a_feed=(0x30,0x30,0x90), b_feed=(0x30,0x30,0x44).
  - t=4: a_feed=(0,0,0x30), b_feed=(0,0,0x20).
- Full run against a behavioral PE model: same A/B, start held high → done in cycle 11 (PE_LAT=1). c_mat = [0x40,0x42,0x42; 0x00,0x38,0x38; 0x34,0x18,0x18]. done stays high while start=1.
- Handshake: drop start in DONE → done=0 the next cycle. Raise start again → second run gives identical c_mat. Change a_mat during FEED → result unchanged.
- Reset mid-run: reset=0 in FEED cycle t=3 → outputs immediately 0. Release and restart → correct result.
- PE_LAT=3: DRAIN lasts 5 cycles and done first rises in cycle 13.
